// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Grant and state encodings plus streak counter sizing.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_F,
      WAIT_D
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_F,
      GNT_D
   } grant_e;

   function automatic int streak_w(input int unsigned max_streak);
      return (max_streak < 2) ? 1 : $clog2(max_streak + 1);
   endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Grant and conflict counters for the memory port arbiter.
// Only built when MEM_ARB_PERF_EN is defined.
module mem_arb_perf
   import mem_arb_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        f_grant,
   input  logic        d_grant,
   input  logic        conflict,
   output logic [31:0] perf_fetch_grants,
   output logic [31:0] perf_data_grants,
   output logic [31:0] perf_conflict_cycles
);

   logic [31:0] fetch_q, fetch_d;
   logic [31:0] data_q, data_d;
   logic [31:0] conf_q, conf_d;

   always_comb begin
      fetch_d = fetch_q + {31'd0, f_grant};
      data_d  = data_q + {31'd0, d_grant};
      conf_d  = conf_q + {31'd0, conflict};
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         fetch_q <= '0;
         data_q  <= '0;
         conf_q  <= '0;
      end else begin
         fetch_q <= fetch_d;
         data_q  <= data_d;
         conf_q  <= conf_d;
      end
   end

   assign perf_fetch_grants    = fetch_q;
   assign perf_data_grants     = data_q;
   assign perf_conflict_cycles = conf_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port shared by fetch and load/store.
// Define MEM_ARB_PERF_EN to build the perf counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned MAX_DATA_STREAK = 4,
   parameter logic [31:0] RESET_ADDR      = 32'h100
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        f_req_stb,
   input  logic [31:0] f_req_addr,
   output logic        f_req_ack,
   input  logic        f_flush,
   output logic        f_rsp_valid,
   output logic [31:0] f_rsp_data,
   input  logic        d_req_stb,
   input  logic        d_req_we,
   input  logic [31:0] d_req_addr,
   input  logic [31:0] d_req_wdata,
   input  logic [3:0]  d_req_wmask,
   output logic        d_req_ack,
   output logic        d_rsp_valid,
   output logic [31:0] d_rsp_data,
   output logic        mem_stb,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic [31:0] perf_fetch_grants,
   output logic [31:0] perf_data_grants,
   output logic [31:0] perf_conflict_cycles
);

   localparam int STREAK_W = streak_w(MAX_DATA_STREAK);
   localparam logic [STREAK_W-1:0] STREAK_MAX =
      STREAK_W'(MAX_DATA_STREAK);

   arb_state_e          state_q, state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;
   logic                drop_q, drop_d;
   logic                mem_stb_q, mem_stb_d;
   logic                mem_we_q, mem_we_d;
   logic [31:0]         mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic [3:0]          mem_wmask_q, mem_wmask_d;
   logic                f_rsp_valid_q, f_rsp_valid_d;
   logic [31:0]         f_rsp_data_q, f_rsp_data_d;
   logic                d_rsp_valid_q, d_rsp_valid_d;
   logic [31:0]         d_rsp_data_q, d_rsp_data_d;

   grant_e grant;
   logic   f_vld, at_max, idle, d_win, f_win;

   always_comb begin
      f_vld  = f_req_stb & ~f_flush;
      at_max = (streak_q == STREAK_MAX);
      idle   = i_reset_n & (state_q == IDLE);
      d_win  = idle & d_req_stb & ~(f_vld & at_max);
      f_win  = idle & f_vld & ~d_win;
      grant  = GNT_NONE;
      unique case (1'b1)
         d_win:   grant = GNT_D;
         f_win:   grant = GNT_F;
         default: ;
      endcase
   end

   assign f_req_ack = (grant == GNT_F);
   assign d_req_ack = (grant == GNT_D);

   always_comb begin
      state_d       = state_q;
      streak_d      = streak_q;
      drop_d        = drop_q;
      mem_stb_d     = 1'b0;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      mem_wmask_d   = mem_wmask_q;
      f_rsp_valid_d = 1'b0;
      f_rsp_data_d  = f_rsp_data_q;
      d_rsp_valid_d = 1'b0;
      d_rsp_data_d  = d_rsp_data_q;
      unique case (state_q)
         IDLE: begin
            unique case (grant)
               GNT_F: begin
                  state_d     = WAIT_F;
                  streak_d    = '0;
                  drop_d      = 1'b0;
                  mem_stb_d   = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = f_req_addr;
                  mem_wdata_d = '0;
                  mem_wmask_d = '0;
               end
               GNT_D: begin
                  state_d     = WAIT_D;
                  mem_stb_d   = 1'b1;
                  mem_we_d    = d_req_we;
                  mem_addr_d  = d_req_addr;
                  mem_wdata_d = d_req_wdata;
                  mem_wmask_d = d_req_wmask;
                  if (!f_vld)
                     streak_d = '0;
                  else if (!at_max)
                     streak_d = streak_q + STREAK_W'(1);
               end
               default: ;
            endcase
         end
         WAIT_F: begin
            if (f_flush)
               drop_d = 1'b1;
            if (mem_rvalid) begin
               state_d = IDLE;
               drop_d  = 1'b0;
               // A flush in the completion cycle still kills it
               if (!drop_q && !f_flush) begin
                  f_rsp_valid_d = 1'b1;
                  f_rsp_data_d  = mem_rdata;
               end
            end
         end
         WAIT_D: begin
            if (mem_rvalid) begin
               state_d       = IDLE;
               d_rsp_valid_d = 1'b1;
               d_rsp_data_d  = mem_we_q ? '0 : mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_q != IDLE && mem_rvalid) begin
         mem_we_d    = 1'b0;
         mem_addr_d  = RESET_ADDR;
         mem_wdata_d = '0;
         mem_wmask_d = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q       <= IDLE;
         streak_q      <= '0;
         drop_q        <= 1'b0;
         mem_stb_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= RESET_ADDR;
         mem_wdata_q   <= '0;
         mem_wmask_q   <= '0;
         f_rsp_valid_q <= 1'b0;
         f_rsp_data_q  <= '0;
         d_rsp_valid_q <= 1'b0;
         d_rsp_data_q  <= '0;
      end else begin
         state_q       <= state_d;
         streak_q      <= streak_d;
         drop_q        <= drop_d;
         mem_stb_q     <= mem_stb_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         mem_wmask_q   <= mem_wmask_d;
         f_rsp_valid_q <= f_rsp_valid_d;
         f_rsp_data_q  <= f_rsp_data_d;
         d_rsp_valid_q <= d_rsp_valid_d;
         d_rsp_data_q  <= d_rsp_data_d;
      end
   end

   assign mem_stb     = mem_stb_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_wmask   = mem_wmask_q;
   assign f_rsp_valid = f_rsp_valid_q;
   assign f_rsp_data  = f_rsp_data_q;
   assign d_rsp_valid = d_rsp_valid_q;
   assign d_rsp_data  = d_rsp_data_q;

`ifdef MEM_ARB_PERF_EN
   logic conflict;
   assign conflict = idle & d_req_stb & f_vld;

   mem_arb_perf u_perf (
      .i_clk                (i_clk),
      .i_reset_n            (i_reset_n),
      .f_grant              (f_req_ack),
      .d_grant              (d_req_ack),
      .conflict             (conflict),
      .perf_fetch_grants    (perf_fetch_grants),
      .perf_data_grants     (perf_data_grants),
      .perf_conflict_cycles (perf_conflict_cycles)
   );
`else
   assign perf_fetch_grants    = '0;
   assign perf_data_grants     = '0;
   assign perf_conflict_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Perf expectations follow MEM_ARB_PERF_EN.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        i_clk = 1'b0;
   logic        i_reset_n;
   logic        f_req_stb;
   logic [31:0] f_req_addr;
   logic        f_req_ack;
   logic        f_flush;
   logic        f_rsp_valid;
   logic [31:0] f_rsp_data;
   logic        d_req_stb;
   logic        d_req_we;
   logic [31:0] d_req_addr;
   logic [31:0] d_req_wdata;
   logic [3:0]  d_req_wmask;
   logic        d_req_ack;
   logic        d_rsp_valid;
   logic [31:0] d_rsp_data;
   logic        mem_stb;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_rdata;
   logic        mem_rvalid;
   logic [31:0] perf_fetch_grants;
   logic [31:0] perf_data_grants;
   logic [31:0] perf_conflict_cycles;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   mem_port_arbiter dut (
      .i_clk                (i_clk),
      .i_reset_n            (i_reset_n),
      .f_req_stb            (f_req_stb),
      .f_req_addr           (f_req_addr),
      .f_req_ack            (f_req_ack),
      .f_flush              (f_flush),
      .f_rsp_valid          (f_rsp_valid),
      .f_rsp_data           (f_rsp_data),
      .d_req_stb            (d_req_stb),
      .d_req_we             (d_req_we),
      .d_req_addr           (d_req_addr),
      .d_req_wdata          (d_req_wdata),
      .d_req_wmask          (d_req_wmask),
      .d_req_ack            (d_req_ack),
      .d_rsp_valid          (d_rsp_valid),
      .d_rsp_data           (d_rsp_data),
      .mem_stb              (mem_stb),
      .mem_we               (mem_we),
      .mem_addr             (mem_addr),
      .mem_wdata            (mem_wdata),
      .mem_wmask            (mem_wmask),
      .mem_rdata            (mem_rdata),
      .mem_rvalid           (mem_rvalid),
      .perf_fetch_grants    (perf_fetch_grants),
      .perf_data_grants     (perf_data_grants),
      .perf_conflict_cycles (perf_conflict_cycles)
   );

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // Holds the requested stbs, answers every issue with zero wait,
   // and returns the grant order of n accepted transactions.
   task automatic serve(input bit fs, input bit ds, input int n,
                        output string seq);
      int cnt = 0;
      seq = "";
      f_req_stb = fs;
      d_req_stb = ds;
      for (int c = 0; c < 60 && cnt < n; c++) begin
         #1;
         mem_rvalid = mem_stb;
         if (d_req_ack) begin
            seq = {seq, "D"};
            cnt++;
         end else if (f_req_ack) begin
            seq = {seq, "F"};
            cnt++;
         end
         tick();
      end
      f_req_stb = 1'b0;
      d_req_stb = 1'b0;
      #1;
      mem_rvalid = mem_stb;
      tick();
      mem_rvalid = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      i_reset_n = 1'b0;
      tick();
      tick();
      checks++;
      if (mem_stb !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL rst_ctl: stb=%b we=%b want 0 0",
                  mem_stb, mem_we);
      end
      checks++;
      if (mem_addr !== 32'h100) begin
         errors++;
         $display("FAIL rst_addr: got %h want 00000100", mem_addr);
      end
      checks++;
      if (mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
         errors++;
         $display("FAIL rst_wr: wdata=%h wmask=%h want 0",
                  mem_wdata, mem_wmask);
      end
      checks++;
      if ({f_rsp_valid, d_rsp_valid, f_req_ack, d_req_ack}
          !== 4'b0) begin
         errors++;
         $display("FAIL rst_flags: got %b want 0000",
                  {f_rsp_valid, d_rsp_valid, f_req_ack, d_req_ack});
      end
      checks++;
      if (f_rsp_data !== 32'h0 || d_rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL rst_data: f=%h d=%h want 0",
                  f_rsp_data, d_rsp_data);
      end
      checks++;
      if (perf_fetch_grants !== 32'h0 || perf_data_grants !== 32'h0
          || perf_conflict_cycles !== 32'h0) begin
         errors++;
         $display("FAIL rst_perf: %0d %0d %0d want 0 0 0",
                  perf_fetch_grants, perf_data_grants,
                  perf_conflict_cycles);
      end
      i_reset_n = 1'b1;
      tick();
   endtask

   task automatic test_single_fetch();
      f_req_stb  = 1'b1;
      f_req_addr = 32'h100;
      #1;
      checks++;
      if (f_req_ack !== 1'b1 || d_req_ack !== 1'b0) begin
         errors++;
         $display("FAIL sf_ack: f=%b d=%b want 1 0",
                  f_req_ack, d_req_ack);
      end
      tick();
      f_req_stb = 1'b0;
      checks++;
      if (mem_stb !== 1'b1 || mem_addr !== 32'h100
          || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL sf_issue: stb=%b addr=%h we=%b want 1 100 0",
                  mem_stb, mem_addr, mem_we);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEADBEEF;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL sf_rsp: v=%b data=%h want 1 deadbeef",
                  f_rsp_valid, f_rsp_data);
      end
      checks++;
      if (mem_stb !== 1'b0) begin
         errors++;
         $display("FAIL sf_stb_pulse: got %b want 0", mem_stb);
      end
      tick();
      checks++;
      if (f_rsp_valid !== 1'b0 || f_rsp_data !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL sf_hold: v=%b data=%h want 0 deadbeef",
                  f_rsp_valid, f_rsp_data);
      end
   endtask

   task automatic test_simultaneous();
      f_req_stb   = 1'b1;
      f_req_addr  = 32'h104;
      d_req_stb   = 1'b1;
      d_req_we    = 1'b1;
      d_req_addr  = 32'h2000;
      d_req_wdata = 32'h55;
      d_req_wmask = 4'hF;
      #1;
      checks++;
      if (d_req_ack !== 1'b1 || f_req_ack !== 1'b0) begin
         errors++;
         $display("FAIL sim_ack: d=%b f=%b want 1 0",
                  d_req_ack, f_req_ack);
      end
      tick();
      d_req_stb = 1'b0;
      checks++;
      if (mem_stb !== 1'b1 || mem_we !== 1'b1
          || mem_addr !== 32'h2000) begin
         errors++;
         $display("FAIL sim_issue: stb=%b we=%b addr=%h want 1 1 2000",
                  mem_stb, mem_we, mem_addr);
      end
      checks++;
      if (mem_wdata !== 32'h55 || mem_wmask !== 4'hF) begin
         errors++;
         $display("FAIL sim_wr: wdata=%h wmask=%h want 55 f",
                  mem_wdata, mem_wmask);
      end
      checks++;
      if (f_req_ack !== 1'b0) begin
         errors++;
         $display("FAIL sim_wait_ack: got %b want 0", f_req_ack);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h12345678;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL sim_drsp: v=%b data=%h want 1 0",
                  d_rsp_valid, d_rsp_data);
      end
      checks++;
      if (f_req_ack !== 1'b1) begin
         errors++;
         $display("FAIL sim_f_gnt: got %b want 1", f_req_ack);
      end
      tick();
      f_req_stb = 1'b0;
      checks++;
      if (mem_stb !== 1'b1 || mem_addr !== 32'h104 || mem_we !== 1'b0
          || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
         errors++;
         $display("FAIL sim_f_issue: stb=%b addr=%h we=%b wd=%h wm=%h",
                  mem_stb, mem_addr, mem_we, mem_wdata, mem_wmask);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hAAAA0001;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'hAAAA0001) begin
         errors++;
         $display("FAIL sim_frsp: v=%b data=%h want 1 aaaa0001",
                  f_rsp_valid, f_rsp_data);
      end
      tick();
   endtask

   task automatic test_starvation();
      string seq;
      d_req_we   = 1'b0;
      d_req_addr = 32'h3000;
      f_req_addr = 32'h108;
      mem_rdata  = 32'h5A5A5A5A;
      serve(1'b1, 1'b1, 6, seq);
      checks++;
      if (seq != "DDDDFD") begin
         errors++;
         $display("FAIL starve_order: got '%s' want 'DDDDFD'", seq);
      end
      checks++;
      if (d_rsp_data !== 32'h5A5A5A5A
          || f_rsp_data !== 32'h5A5A5A5A) begin
         errors++;
         $display("FAIL starve_data: d=%h f=%h want 5a5a5a5a",
                  d_rsp_data, f_rsp_data);
      end
   endtask

   task automatic test_flush();
      f_req_stb  = 1'b1;
      f_req_addr = 32'h1F0;
      f_flush    = 1'b1;
      #1;
      checks++;
      if (f_req_ack !== 1'b0) begin
         errors++;
         $display("FAIL fl_mask: got %b want 0", f_req_ack);
      end
      f_flush = 1'b0;
      #1;
      checks++;
      if (f_req_ack !== 1'b1) begin
         errors++;
         $display("FAIL fl_ack: got %b want 1", f_req_ack);
      end
      tick();
      f_req_stb = 1'b0;
      f_flush   = 1'b1;
      tick();
      f_flush    = 1'b0;
      f_req_stb  = 1'b1;
      f_req_addr = 32'h200;
      #1;
      checks++;
      if (f_req_ack !== 1'b0) begin
         errors++;
         $display("FAIL fl_wait_ack: got %b want 0", f_req_ack);
      end
      tick();
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hBAD0BAD0;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if (f_rsp_valid !== 1'b0 || f_rsp_data !== 32'h5A5A5A5A) begin
         errors++;
         $display("FAIL fl_drop: v=%b data=%h want 0 5a5a5a5a",
                  f_rsp_valid, f_rsp_data);
      end
      checks++;
      if (f_req_ack !== 1'b1) begin
         errors++;
         $display("FAIL fl_new_ack: got %b want 1", f_req_ack);
      end
      tick();
      f_req_stb = 1'b0;
      checks++;
      if (mem_stb !== 1'b1 || mem_addr !== 32'h200) begin
         errors++;
         $display("FAIL fl_new_issue: stb=%b addr=%h want 1 200",
                  mem_stb, mem_addr);
      end
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h13579BDF;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if (f_rsp_valid !== 1'b1 || f_rsp_data !== 32'h13579BDF) begin
         errors++;
         $display("FAIL fl_new_rsp: v=%b data=%h want 1 13579bdf",
                  f_rsp_valid, f_rsp_data);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      d_req_stb  = 1'b1;
      d_req_we   = 1'b0;
      d_req_addr = 32'h4000;
      #1;
      checks++;
      if (d_req_ack !== 1'b1) begin
         errors++;
         $display("FAIL rm_ack: got %b want 1", d_req_ack);
      end
      tick();
      d_req_stb = 1'b0;
      tick();
      i_reset_n = 1'b0;
      tick();
      checks++;
      if (mem_stb !== 1'b0 || mem_addr !== 32'h100 || mem_we !== 1'b0
          || mem_wdata !== 32'h0 || mem_wmask !== 4'h0) begin
         errors++;
         $display("FAIL rm_mem: stb=%b addr=%h we=%b wd=%h wm=%h",
                  mem_stb, mem_addr, mem_we, mem_wdata, mem_wmask);
      end
      checks++;
      if (d_rsp_data !== 32'h0 || f_rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL rm_data: d=%h f=%h want 0",
                  d_rsp_data, f_rsp_data);
      end
      i_reset_n  = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hFFFF0000;
      tick();
      mem_rvalid = 1'b0;
      checks++;
      if (d_rsp_valid !== 1'b0 || d_rsp_data !== 32'h0) begin
         errors++;
         $display("FAIL rm_stale: v=%b data=%h want 0 0",
                  d_rsp_valid, d_rsp_data);
      end
      d_req_stb = 1'b1;
      #1;
      checks++;
      if (d_req_ack !== 1'b1) begin
         errors++;
         $display("FAIL rm_idle: ack=%b want 1", d_req_ack);
      end
      d_req_stb = 1'b0;
      tick();
   endtask

   task automatic test_perf();
      string seq;
      d_req_we   = 1'b0;
      d_req_addr = 32'h5000;
      f_req_addr = 32'h300;
      serve(1'b1, 1'b1, 5, seq);
      checks++;
      if (seq != "DDDDF") begin
         errors++;
         $display("FAIL perf_order1: got '%s' want 'DDDDF'", seq);
      end
      serve(1'b1, 1'b0, 2, seq);
      checks++;
      if (seq != "FF") begin
         errors++;
         $display("FAIL perf_order2: got '%s' want 'FF'", seq);
      end
      checks++;
      if (perf_fetch_grants !== (PERF ? 32'd3 : 32'd0)) begin
         errors++;
         $display("FAIL perf_fetch: got %0d want %0d",
                  perf_fetch_grants, PERF ? 3 : 0);
      end
      checks++;
      if (perf_data_grants !== (PERF ? 32'd4 : 32'd0)) begin
         errors++;
         $display("FAIL perf_data: got %0d want %0d",
                  perf_data_grants, PERF ? 4 : 0);
      end
      checks++;
      if (perf_conflict_cycles !== (PERF ? 32'd5 : 32'd0)) begin
         errors++;
         $display("FAIL perf_conf: got %0d want %0d",
                  perf_conflict_cycles, PERF ? 5 : 0);
      end
   endtask

   initial begin
      i_reset_n   = 1'b0;
      f_req_stb   = 1'b0;
      f_req_addr  = 32'h0;
      f_flush     = 1'b0;
      d_req_stb   = 1'b0;
      d_req_we    = 1'b0;
      d_req_addr  = 32'h0;
      d_req_wdata = 32'h0;
      d_req_wmask = 4'h0;
      mem_rdata   = 32'h0;
      mem_rvalid  = 1'b0;
      test_reset();
      test_single_fetch();
      test_simultaneous();
      test_starvation();
      test_flush();
      test_reset_mid();
      test_perf();
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
